// File: rtl/prbs_pkg.sv
// prbs_pkg: shared constants and helpers for the 4-bit PRBS (x^4+x^3+1).
//   PRBS_W       LFSR width
//   TAP_HI/TAP_LO feedback taps, oldest/newest bit of the history
//   PRBS_SEED    seed used by the transmit-side source
//   PRBS_PERIOD  sequence length
//   state_t      checker FSM states
//   prbs_next()  one LFSR step; the new LSB is the serialized bit
package prbs_pkg;

  localparam int PRBS_W      = 4;
  localparam int TAP_HI      = 3;
  localparam int TAP_LO      = 0;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 4'b1001;
  localparam int PRBS_PERIOD = 15;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the 4-bit PRBS stream.
// Self-synchronizes on the incoming bits, declares lock, then free-runs a
// local reference and counts bit errors.
//
// state  | meaning
// SEARCH | history loads from the line; counts consecutive correct predictions
// LOCKED | history free-runs; mismatches counted, too many in a row -> SEARCH
//
// Ports:
//   clk, rst     clock (rising edge), async active-high reset
//   in_valid     in_bit is sampled on edges where this is high
//   in_bit       received serial bit
//   clr_cnt      synchronous clear of err_count/bit_count (wins over counting)
//   locked       registered, high in LOCKED
//   err_pulse    one-cycle pulse after a mismatching bit in LOCKED
//   err_count    saturating mismatch count while LOCKED
//   bit_count    saturating checked-bit count while LOCKED
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRS + 1);

  state_t              state;
  logic [PRBS_W-1:0]   hist;
  logic [2:0]          fill;
  logic [MATCH_W-1:0]  match;
  logic [MISS_W-1:0]   miss;
  logic                pred;
  logic                mismatch;

  assign pred     = hist[TAP_HI] ^ hist[TAP_LO];
  assign mismatch = (in_bit != pred);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      hist      <= '0;
      fill      <= '0;
      match     <= '0;
      miss      <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            hist <= {hist[PRBS_W-2:0], in_bit};
            if (fill < 3'(PRBS_W)) begin
              fill <= fill + 3'd1;
            end else if (!mismatch && (hist != '0)) begin
              // All-zero history predicts zero forever; never trust it.
              if (match == MATCH_W'(LOCK_COUNT - 1)) begin
                state <= LOCKED;
                match <= '0;
                miss  <= '0;
              end else begin
                match <= match + 1'b1;
              end
            end else begin
              match <= '0;
            end
          end
          LOCKED: begin
            // Reference free-runs so a line error does not corrupt it.
            hist <= prbs_next(hist);
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (miss == MISS_W'(UNLOCK_ERRS - 1)) begin
                state <= SEARCH;
                fill  <= '0;
                match <= '0;
                miss  <= '0;
              end else begin
                miss <= miss + 1'b1;
              end
            end else begin
              miss <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (clr_cnt) begin
      err_count <= '0;
      bit_count <= '0;
    end else if (in_valid && (state == LOCKED)) begin
      if (bit_count != '1) bit_count <= bit_count + 1'b1;
      if (mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed scenarios for prbs_checker. A second instance
// with narrow counters and a large unlock threshold shares the stimulus and
// exposes counter saturation.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] bit_count;
  logic        locked2;
  logic        err_pulse2;
  logic [3:0]  err_count2;
  logic [3:0]  bit_count2;

  int tests = 0;
  int fails = 0;
  int pos   = 0;
  bit seq [15] = '{0,0,0,1,1,1,1,0,1,0,1,1,0,0,1};

  always #5 clk = ~clk;

  prbs_checker #(.LOCK_COUNT(8), .UNLOCK_ERRS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  prbs_checker #(.LOCK_COUNT(8), .UNLOCK_ERRS(1000), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clr_cnt(clr_cnt), .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2), .bit_count(bit_count2)
  );

  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_clean();
    drive(1'b1, seq[pos], 1'b0);
    pos = (pos + 1) % 15;
  endtask

  task automatic send_flipped(input logic c);
    drive(1'b1, ~seq[pos], c);
    pos = (pos + 1) % 15;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    clr_cnt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %b exp 0", locked); end
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL reset_err_pulse got %b exp 0", err_pulse); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL reset_bit_count got %0d exp 0", bit_count); end
  endtask

  task automatic test_clean_lock();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send_clean();
      if (i < 12) begin
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL early_lock bit %0d got %b exp 0", i, locked); end
      end
    end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_after_12 got %b exp 1", locked); end
    for (int i = 0; i < 100; i++) send_clean();
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL clean_err_count got %0d exp 0", err_count); end
    tests++; if (bit_count !== 16'd100) begin fails++; $display("FAIL clean_bit_count got %0d exp 100", bit_count); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL clean_locked got %b exp 1", locked); end
  endtask

  task automatic test_single_flip();
    int pulses;
    pulses = 0;
    send_flipped(1'b0);
    tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL flip_pulse got %b exp 1", err_pulse); end
    for (int i = 0; i < 15; i++) begin
      send_clean();
      if (err_pulse) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL flip_extra_pulses got %0d exp 0", pulses); end
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL flip_err_count got %0d exp 1", err_count); end
    tests++; if (bit_count !== 16'd116) begin fails++; $display("FAIL flip_bit_count got %0d exp 116", bit_count); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL flip_locked got %b exp 1", locked); end
  endtask

  task automatic test_stuck_locked();
    int  run;
    int  exp_err;
    bit  exp_locked;
    bit  tb;
    run = 0; exp_err = 1; exp_locked = 1'b1;
    for (int i = 0; i < 30 && exp_locked; i++) begin
      tb = seq[pos];
      drive(1'b1, 1'b0, 1'b0);
      pos = (pos + 1) % 15;
      if (tb) begin run++; exp_err++; end else run = 0;
      if (run == 4) exp_locked = 1'b0;
      tests++; if (locked !== exp_locked) begin fails++; $display("FAIL stuck_locked_state step %0d got %b exp %b", i, locked, exp_locked); end
      tests++; if (err_pulse !== tb) begin fails++; $display("FAIL stuck_locked_pulse step %0d got %b exp %b", i, err_pulse, tb); end
    end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL stuck_unlock_timeout got %b exp 0", locked); end
    tests++; if (err_count !== 16'(exp_err)) begin fails++; $display("FAIL stuck_err_count got %0d exp %0d", err_count, exp_err); end
  endtask

  task automatic test_stuck_search();
    int highs;
    highs = 0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (locked !== 1'b0) highs++;
    end
    tests++; if (highs != 0) begin fails++; $display("FAIL stuck0_locked cycles_high %0d exp 0", highs); end
    tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL stuck0_bit_count got %0d exp 0", bit_count); end
  endtask

  task automatic test_valid_toggle();
    logic jb;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send_clean();
      if (i < 12) begin
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL toggle_early_lock bit %0d got %b exp 0", i, locked); end
      end
      jb = 1'($urandom_range(0, 1));
      drive(1'b0, jb, 1'b0);
    end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL toggle_lock got %b exp 1", locked); end
    for (int k = 1; k <= 10; k++) begin
      send_clean();
      jb = 1'($urandom_range(0, 1));
      drive(1'b0, jb, 1'b0);
      tests++; if (bit_count !== 16'(k)) begin fails++; $display("FAIL toggle_bit_count got %0d exp %0d", bit_count, k); end
      tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL toggle_pulse got %b exp 0", err_pulse); end
    end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL toggle_err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_clr_coincide();
    send_flipped(1'b1);
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL clr_err_count got %0d exp 0", err_count); end
    tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL clr_bit_count got %0d exp 0", bit_count); end
    tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL clr_pulse got %b exp 1", err_pulse); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL clr_locked got %b exp 1", locked); end
    send_clean();
    tests++; if (bit_count !== 16'd1) begin fails++; $display("FAIL post_clr_bit_count got %0d exp 1", bit_count); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL post_clr_err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_async_reset();
    send_flipped(1'b0);
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL prereset_err_count got %0d exp 1", err_count); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL async_locked got %b exp 0", locked); end
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL async_pulse got %b exp 0", err_pulse); end
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL async_err_count got %0d exp 0", err_count); end
    tests++; if (bit_count !== 16'd0) begin fails++; $display("FAIL async_bit_count got %0d exp 0", bit_count); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 12; i++) send_clean();
    tests++; if (locked2 !== 1'b1) begin fails++; $display("FAIL sat_lock got %b exp 1", locked2); end
    for (int i = 0; i < 20; i++) send_flipped(1'b0);
    tests++; if (err_count2 !== 4'd15) begin fails++; $display("FAIL sat_err_count got %0d exp 15", err_count2); end
    tests++; if (bit_count2 !== 4'd15) begin fails++; $display("FAIL sat_bit_count got %0d exp 15", bit_count2); end
    tests++; if (locked2 !== 1'b1) begin fails++; $display("FAIL sat_locked got %b exp 1", locked2); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL unlock4_locked got %b exp 0", locked); end
    tests++; if (err_count !== 16'd4) begin fails++; $display("FAIL unlock4_err_count got %0d exp 4", err_count); end
    tests++; if (bit_count !== 16'd4) begin fails++; $display("FAIL unlock4_bit_count got %0d exp 4", bit_count); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_stuck_locked();
    test_stuck_search();
    test_valid_toggle();
    test_clr_coincide();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
